// File: rtl/key_matrix_scanner.sv
// 4x4 keypad scanner: rotates a one-hot row drive, debounces all 16 keys and
// reports press events through a valid/ack handshake with a sticky overflow.
module key_matrix_scanner #(
  parameter int SCAN_DIV = 100,
  parameter int DEBOUNCE = 4
) (
  input  logic        gclk,
  input  logic        greset,
  input  logic [3:0]  KeyX,
  output logic [3:0]  KeyY,
  output logic [15:0] key_state,
  output logic        key_valid,
  output logic [3:0]  key_code,
  input  logic        key_ack,
  output logic        key_ovf
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE - 1);

  logic [3:0]    x_meta;
  logic [3:0]    x_sync;
  logic [DW-1:0] dwell;
  logic [1:0]    row;
  logic          sample;
  logic [CW-1:0] db_cnt     [16];
  logic [CW-1:0] db_cnt_nxt [16];
  logic [15:0]   state_nxt;
  logic [3:0]    rise;
  logic [1:0]    win_col;
  logic          multi;
  logic          evt;

  assign sample = (dwell == DWELL_LAST);

  always_comb begin
    case (KeyY)
      4'b0010: row = 2'd1;
      4'b0100: row = 2'd2;
      4'b1000: row = 2'd3;
      default: row = 2'd0;
    endcase
  end

  // Only the four keys of the row being sampled move; a flip is a rise when
  // the newly accepted level is 1.
  always_comb begin
    state_nxt = key_state;
    rise      = '0;
    for (int k = 0; k < 16; k++) begin
      db_cnt_nxt[k] = db_cnt[k];
      if (sample && (k / 4) == int'(row)) begin
        if (x_sync[k % 4] == key_state[k]) begin
          db_cnt_nxt[k] = '0;
        end else if (db_cnt[k] == DB_LAST) begin
          state_nxt[k]  = x_sync[k % 4];
          db_cnt_nxt[k] = '0;
          rise[k % 4]   = x_sync[k % 4];
        end else begin
          db_cnt_nxt[k] = db_cnt[k] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    win_col = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (rise[c]) win_col = 2'(c);
    end
  end

  assign evt   = |rise;
  assign multi = (rise & (rise - 4'd1)) != 4'd0;

  always_ff @(posedge gclk) begin
    if (greset) begin
      x_meta    <= '0;
      x_sync    <= '0;
      dwell     <= '0;
      KeyY      <= 4'b0001;
      key_state <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_ovf   <= 1'b0;
      for (int k = 0; k < 16; k++) db_cnt[k] <= '0;
    end else begin
      x_meta    <= KeyX;
      x_sync    <= x_meta;
      key_state <= state_nxt;
      for (int k = 0; k < 16; k++) db_cnt[k] <= db_cnt_nxt[k];
      if (sample) begin
        dwell <= '0;
        KeyY  <= {KeyY[2:0], KeyY[3]};
      end else begin
        dwell <= dwell + DW'(1);
      end
      // An ack on the loading edge frees the slot for the new event.
      if (evt && (!key_valid || key_ack)) begin
        key_valid <= 1'b1;
        key_code  <= {row, win_col};
      end else if (key_ack) begin
        key_valid <= 1'b0;
      end
      if (multi || (evt && key_valid && !key_ack)) key_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_key_matrix_scanner.sv
// Bench for key_matrix_scanner: a keypad model drives KeyX from KeyY, a
// per-scan reference model predicts the key map and events for a scoreboard.
module tb_key_matrix_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int SCAN     = 4 * SCAN_DIV;

  logic        gclk = 1'b0;
  logic        greset = 1'b1;
  logic        key_ack = 1'b0;
  logic [3:0]  KeyX;
  logic [3:0]  KeyY;
  logic [15:0] key_state;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ovf;
  logic [15:0] pressed = '0;

  int vectors = 0;
  int miscompares = 0;

  key_matrix_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .gclk(gclk), .greset(greset), .KeyX(KeyX), .KeyY(KeyY),
    .key_state(key_state), .key_valid(key_valid), .key_code(key_code),
    .key_ack(key_ack), .key_ovf(key_ovf)
  );

  always #5 gclk = ~gclk;

  // Physical keypad: a pressed key shorts its row drive onto its column.
  always_comb begin
    KeyX = '0;
    for (int r = 0; r < 4; r++) if (KeyY[r]) KeyX |= pressed[4*r +: 4];
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edges since reset, per-key run of differing samples.
  int          m_cyc = 0;
  logic [15:0] m_state = '0;
  int          m_run [16];
  bit          m_valid = 0;
  bit          m_ovf = 0;
  int          m_code = 0;
  int          exp_q [$];
  bit          started = 0;

  always @(posedge gclk) begin
    int win, lost, r, k;
    if (greset) begin
      started = 1;
      m_cyc = 0;
      m_state = '0;
      for (int i = 0; i < 16; i++) m_run[i] = 0;
      m_valid = 0;
      m_ovf = 0;
      m_code = 0;
      exp_q.delete();
    end else begin
      win = -1;
      lost = 0;
      if (m_cyc % SCAN_DIV == SCAN_DIV - 1) begin
        r = (m_cyc / SCAN_DIV) % 4;
        for (int c = 0; c < 4; c++) begin
          k = 4 * r + c;
          if (pressed[k] != m_state[k]) begin
            m_run[k]++;
            if (m_run[k] == DEBOUNCE) begin
              m_state[k] = pressed[k];
              m_run[k] = 0;
              if (pressed[k]) begin
                if (win < 0) win = k;
                else lost++;
              end
            end
          end else begin
            m_run[k] = 0;
          end
        end
      end
      if (lost > 0) m_ovf = 1;
      if (win >= 0) begin
        if (!m_valid || key_ack) begin
          m_valid = 1;
          m_code = win;
          exp_q.push_back(win);
        end else begin
          m_ovf = 1;
        end
      end else if (key_ack) begin
        m_valid = 0;
      end
      m_cyc++;
    end
  end

  // Monitor: every cycle compare against the model; pop an event whenever the
  // DUT presents a freshly loaded one.
  bit prev_valid = 0;
  always @(posedge gclk) begin
    logic [3:0] ey;
    #1;
    if (started) begin
      ey = '0;
      ey[(m_cyc / SCAN_DIV) % 4] = 1'b1;
      chk("KeyY", KeyY, ey);
      chk("key_state", key_state, m_state);
      chk("key_valid", key_valid, m_valid);
      chk("key_ovf", key_ovf, m_ovf);
      chk("key_code", key_code, m_code);
      if (key_valid && (!prev_valid || key_ack)) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL evt_unexpected: DUT presented code %0d, none expected", key_code);
        end else begin
          chk("evt_code", key_code, exp_q.pop_front());
        end
      end
      if (exp_q.size() != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL evt_missing: no event presented, expected code %0d", exp_q[0]);
        exp_q.delete();
      end
      prev_valid = key_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge gclk);
  endtask

  task automatic next_scan();
    int g = 0;
    do begin
      @(negedge gclk);
      g++;
    end while (m_cyc % SCAN != 0 && g < 2 * SCAN);
    if (g >= 2 * SCAN) begin
      vectors++;
      miscompares++;
      $display("FAIL scan_align: got cycle %0d expected scan boundary", m_cyc);
    end
  endtask

  task automatic run_scans(input int n);
    repeat (n) next_scan();
  endtask

  task automatic align();
    if (m_cyc % SCAN != 0) next_scan();
  endtask

  task automatic hold(input logic [15:0] p, input int n);
    align();
    pressed = p;
    run_scans(n);
  endtask

  task automatic wait_phase(input int ph);
    int g = 0;
    while (m_cyc % SCAN != ph && g < 2 * SCAN) begin
      @(negedge gclk);
      g++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick(2);
    chk("rst_KeyY", KeyY, 16'h0001);
    chk("rst_state", key_state, 16'h0000);
    chk("rst_valid", key_valid, 16'h0000);
    greset = 1'b0;
    run_scans(1);

    hold(16'h0040, 3);
    chk("t2_state6", key_state[6], 16'h0001);
    chk("t2_valid", key_valid, 16'h0001);
    chk("t2_code", key_code, 16'h0006);
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    chk("t2_ack_clear", key_valid, 16'h0000);

    hold(16'h0000, 3);
    chk("t3_release", key_state, 16'h0000);
    hold(16'h0040, 2);
    hold(16'h0000, 3);
    chk("t3_bounce_state", key_state, 16'h0000);
    chk("t3_bounce_valid", key_valid, 16'h0000);
    chk("t3_bounce_ovf", key_ovf, 16'h0000);

    hold(16'hA000, 3);
    chk("t4_row3", key_state[15:12], 16'h000A);
    chk("t4_code", key_code, 16'h000D);
    chk("t4_ovf", key_ovf, 16'h0001);
    hold(16'hA001, 3);
    chk("t4_drop_code", key_code, 16'h000D);
    chk("t4_drop_ovf", key_ovf, 16'h0001);

    hold(16'hA021, 2);
    wait_phase(4 * 1 + SCAN_DIV - 1);
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    chk("t5_valid", key_valid, 16'h0001);
    chk("t5_code", key_code, 16'h0005);
    chk("t5_ovf", key_ovf, 16'h0001);
    hold(16'h0000, 3);
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;

    hold(16'h0200, 2);
    greset = 1'b1;
    tick(2);
    chk("t6_KeyY", KeyY, 16'h0001);
    chk("t6_state", key_state, 16'h0000);
    chk("t6_valid", key_valid, 16'h0000);
    chk("t6_ovf", key_ovf, 16'h0000);
    chk("t6_code", key_code, 16'h0000);
    greset = 1'b0;
    hold(16'h0200, 2);
    chk("t6_not_yet", key_state[9], 16'h0000);
    run_scans(1);
    chk("t6_accepted", key_state[9], 16'h0001);
    chk("t6_code9", key_code, 16'h0009);

    for (int it = 0; it < 40; it++) begin
      align();
      pressed = 16'($urandom & $urandom);
      n = $urandom_range(1, 4);
      repeat (n * SCAN) begin
        key_ack = ($urandom_range(0, 2) == 0);
        @(negedge gclk);
      end
      key_ack = 1'b0;
    end

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/key_matrix_scanner.md
Name: key_matrix_scanner

Overview:
Drives the 4x4 keypad row lines one-hot, samples the column lines, debounces all 16 keys and presents a 16-bit stable key map to the Cortex-M3 GPIO input bus. Sits directly upstream of the EMPU gpioin port, replacing the raw per-row capture in the top level. Also produces a press-event code with a valid/ack handshake, so firmware can read keys without polling the full map.

Parameters:
SCAN_DIV, 100, gclk cycles spent on each row (dwell); minimum 4
DEBOUNCE, 4, consecutive row samples required to accept a key change; minimum 1

Ports:
gclk  input  1  27 MHz system clock
greset  input  1  synchronous reset, active-high
KeyX  input  4  keypad column inputs, 1 = pressed, asynchronous
KeyY  output  4  keypad row drive, one-hot
key_state  output  16  debounced key map; bit 4*r+c = row r, column c
key_valid  output  1  press event pending
key_code  output  4  code of pending press, 4*r+c
key_ack  input  1  consumer accepts pending event
key_ovf  output  1  sticky: a press event was lost

Behaviour:
- Reset (greset=1 at gclk edge): KeyY=4'b0001, dwell counter=0, sync flops=0, all debounce counters=0, key_state=0, key_valid=0, key_code=0, key_ovf=0. Reset mid-debounce or mid-event discards all progress.
- KeyX passes through a 2-flop synchronizer before any use.
- Dwell counter runs 0..SCAN_DIV-1. At count==SCAN_DIV-1 the synchronized KeyX is sampled for the current row r, where r is the index of the set KeyY bit. On the same edge the counter wraps to 0 and KeyY rotates left: 0001->0010->0100->1000->0001. A full scan takes 4*SCAN_DIV cycles.
- Per-key debounce counter, width clog2(DEBOUNCE+1). It updates only on a sample of that key's row:
  - sample == key_state bit: counter=0.
  - sample != bit and counter==DEBOUNCE-1: bit flips, counter=0.
  - otherwise: counter+1.
- A change is therefore accepted on the DEBOUNCE-th consecutive differing sample. With DEBOUNCE=1 it is accepted on the first.
- key_state updates on the sample edge and is registered; no combinational path from KeyX.
- Press event: a 0->1 flip of any key on a sample edge.
  - If several keys of the row flip 0->1 on the same edge, the lowest column wins. Each other flip counts as a lost event and sets key_ovf. All bits still update in key_state.
  - Release flips (1->0) produce no event.
- Event handshake:
  - key_valid=1 holds key_code stable until a cycle with key_ack=1. key_valid clears on that cycle unless a new event loads on the same edge.
  - Loading rule: a new event loads when key_valid=0, or when key_valid=1 and key_ack=1 on the same edge. Either way key_code takes the new value and key_valid is 1 next cycle.
  - New event while key_valid=1 and key_ack=0: event is dropped, key_code is unchanged, key_ovf=1.
  - key_ack while key_valid=0 is ignored.
- key_ovf clears only on greset.
- Latency: from a KeyX change stable before the sync flops, to the key_state flip, at most 2 + DEBOUNCE*4*SCAN_DIV cycles.
- key_state connects straight to gpioin[15:0]; the bit mapping matches row-major nibble order (row 0 -> [3:0]).

Test Plan:
(Bench uses SCAN_DIV=4, DEBOUNCE=3.)
1. Assert greset 2 cycles, release -> KeyY=0001, key_state=0, key_valid=0, key_ovf=0; KeyY steps 0001->0010->0100->1000->0001 every 4 cycles.
2. KeyX=4'b0100 held only while KeyY=0010, across 3 full scans -> key_state[6]=1 after the 3rd row-1 sample; key_valid=1, key_code=6. Apply key_ack for 1 cycle -> key_valid=0.
3. Bounce: key pressed for 2 row-1 samples, then released -> key_state stays 0, no key_valid, key_ovf=0. Release after an accepted press -> bit clears after 3 samples, no event.
4. KeyX=4'b1010 on row 3 until accepted -> key_state[15:12]=1010, key_code=13, key_ovf=1. Press key 0 (row 0, col 0) with no ack -> key_code stays 13, key_ovf stays 1.
5. New press accepted on the same edge as key_ack -> key_valid stays 1, key_code=new code, key_ovf unchanged.
6. greset pulsed after 2 of 3 debounce samples -> all outputs return to reset values; the key then needs 3 fresh samples to be accepted.
